muntjac_metadata_ctrl: RTL and testbench
========================================

MUNTJAC_METADATA_CTRL -- requirements
Module: muntjac_metadata_ctrl

Interface
REQ-001 SHALL have parameter NumEntries, default 16, number of 8-bit metadata state entries (power of 2, >=2).
REQ-002 SHALL have parameter NumReq, default 2, number of requester ports.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, ports clk_i and rst_ni.
REQ-004 SHALL have ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  NumReq  request valid per port
- req_ready_o  out  NumReq  request accepted per port
- req_idx_i  in  NumReq x log2(NumEntries)  entry index per port
- req_event_i  in  NumReq x 4  event code per port
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_port_o  out  log2(NumReq), min 1  port that issued the response
- resp_old_o  out  8  entry state before update
- resp_new_o  out  8  entry state after update
- resp_err_o  out  1  event or stored state out of table range
- clear_i  in  1  pulse: reset all entries to 0
- busy_o  out  1  clear pending or in progress

Function
REQ-005 SHALL hold NumEntries x 8-bit state registers.
REQ-006 SHALL select one requester per cycle round-robin; the pointer SHALL advance to one past the granted port on each accept.
REQ-007 SHALL assert req_ready_o for at most one port, and only when the stage register is empty or is firing that cycle, no clear is pending, and FSM=IDLE.
REQ-008 On accept, SHALL latch port, index and event into a single stage register; resp_valid_o SHALL rise the next cycle (latency 1).
REQ-009 SHALL compute resp_new_o combinationally from the stored entry and the latched event via the transition table: event0 and event1 are identity; event2 maps 0->1 and holds other states; event3 maps 1->2 and holds other states.
REQ-010 For event>3 or stored state>3, SHALL set resp_new_o=resp_old_o and resp_err_o=1.
REQ-011 SHALL write resp_new_o to the entry only on resp_valid_o & resp_ready_i.
REQ-012 SHALL hold resp_* stable while resp_valid_o & !resp_ready_i.
REQ-013 SHALL accept a new request in the same cycle a response fires, giving one update per cycle; a back-to-back request to the same index SHALL read the written-back value, with no forwarding path needed.
REQ-014 SHALL implement FSM states IDLE and CLEAR:
- clear_i in IDLE SHALL set clear_pending
- IDLE->CLEAR when clear_pending and the stage is empty
- in CLEAR, SHALL zero one entry per cycle from index 0 upward
- CLEAR->IDLE after entry NumEntries-1; the counter SHALL wrap to 0
REQ-015 SHALL ignore clear_i asserted during CLEAR or while clear_pending.
REQ-016 SHALL drive busy_o = clear_pending | (FSM==CLEAR).
REQ-017 A stage-register response pending when clear_i arrives SHALL complete and write back before CLEAR starts.

Reset
REQ-018 SHALL reset, on rst_ni low:
- all entries=0
- stage empty, so resp_valid_o=0
- FSM=IDLE, clear_pending=0, clear counter=0
- RR pointer=0
- busy_o=0, req_ready_o=0 during reset
REQ-019 Reset asserted mid-transaction SHALL discard the pending response with no write-back.

Structure
REQ-020 SHALL place the FSM state enum, the event code constants (0..3) and the state-width constant (8) in the shared pipeline package.
REQ-021 SHALL instantiate muntjac_metadata_table for the transition lookup; its valid_i SHALL be driven low when the event or state is out of range.

Verification
REQ-022 Port0 event2 idx5 (entry=0), resp_ready=1 -> next cycle resp_old=0, resp_new=1, port=0, err=0; entry5=1.
REQ-023 Both ports valid continuously, RR pointer=0 -> grants alternate 0,1,0,1; one response per cycle.
REQ-024 Back-to-back event2 then event3 on idx3 (entry=0) -> responses 0->1 then 1->2; entry3=2.
REQ-025 Event 7 on idx1 -> err=1, new=old, entry unchanged.
REQ-026 resp_ready=0 for 3 cycles -> outputs stable, req_ready=0, no write; write occurs on the 4th-cycle fire.
REQ-027 clear_i with a response pending -> response completes, then busy_o=1 for NumEntries cycles, all entries read 0 afterwards; rst_ni low mid-CLEAR -> IDLE, busy_o=0.

Source files
------------

// File: rtl/muntjac_metadata_ctrl_pkg.sv
// Shared definitions for the metadata controller: FSM states, event codes,
// state width and the table range check.
package muntjac_metadata_ctrl_pkg;

    localparam int unsigned StateWidth = 8;
    localparam int unsigned EventWidth = 4;

    localparam logic [EventWidth-1:0] EvNop0   = 4'd0;
    localparam logic [EventWidth-1:0] EvNop1   = 4'd1;
    localparam logic [EventWidth-1:0] EvOpen   = 4'd2;
    localparam logic [EventWidth-1:0] EvCommit = 4'd3;

    localparam logic [StateWidth-1:0] MaxState = 8'd3;

    typedef enum logic [0:0] {
        FsmIdle  = 1'b0,
        FsmClear = 1'b1
    } fsm_e;

    // True when both the event and the stored state are covered by the table.
    function automatic logic state_in_range(input logic [StateWidth-1:0] st,
                                            input logic [EventWidth-1:0] ev);
        return (ev <= EvCommit) && (st <= MaxState);
    endfunction

endpackage

// File: rtl/muntjac_metadata_table.sv
// Metadata state transition lookup; an invalid lookup passes the state through.
module muntjac_metadata_table
    import muntjac_metadata_ctrl_pkg::*;
(
    input  logic                  valid_i,
    input  logic [StateWidth-1:0] state_i,
    input  logic [EventWidth-1:0] event_i,
    output logic [StateWidth-1:0] state_o
);

    // Transition table: open takes 0->1, commit takes 1->2, all else holds.
    always_comb begin
        state_o = state_i;
        if (valid_i) begin
            case (event_i)
                EvOpen:   state_o = (state_i == 8'd0) ? 8'd1 : state_i;
                EvCommit: state_o = (state_i == 8'd1) ? 8'd2 : state_i;
                default:  state_o = state_i;
            endcase
        end else begin
            state_o = state_i;
        end
    end

endmodule

// File: rtl/muntjac_metadata_ctrl.sv
// Metadata state controller: round-robin requesters, one-deep stage register,
// read-modify-write of an 8-bit state table, and a sequential clear engine.
module muntjac_metadata_ctrl
    import muntjac_metadata_ctrl_pkg::*;
#(
    parameter int unsigned NumEntries = 16,
    parameter int unsigned NumReq     = 2,
    localparam int unsigned IdxW      = $clog2(NumEntries),
    localparam int unsigned PortW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq*IdxW-1:0]       req_idx_i,
    input  logic [NumReq*EventWidth-1:0] req_event_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [PortW-1:0]             resp_port_o,
    output logic [StateWidth-1:0]        resp_old_o,
    output logic [StateWidth-1:0]        resp_new_o,
    output logic                         resp_err_o,
    input  logic                         clear_i,
    output logic                         busy_o
);

    logic [StateWidth-1:0] entry_r [NumEntries];

    logic                  stage_valid_r;
    logic [PortW-1:0]      stage_port_r;
    logic [IdxW-1:0]       stage_idx_r;
    logic [EventWidth-1:0] stage_event_r;

    fsm_e                  fsm_r, fsm_next_s;
    logic                  clear_pending_r, pending_next_s;
    logic [IdxW-1:0]       clr_cnt_r;
    logic [PortW-1:0]      rr_ptr_r, rr_next_s;

    logic                  resp_fire_s, can_accept_s, accept_s, grant_found_s, in_range_s;
    logic [PortW-1:0]      grant_port_s;
    logic [IdxW-1:0]       sel_idx_s;
    logic [EventWidth-1:0] sel_event_s;
    logic [StateWidth-1:0] old_state_s, new_state_s;

    function automatic logic [PortW-1:0] wrap_port(input int unsigned p);
        return PortW'(p % NumReq);
    endfunction

    assign resp_fire_s = stage_valid_r & resp_ready_i;
    assign old_state_s = entry_r[stage_idx_r];
    assign in_range_s  = state_in_range(old_state_s, stage_event_r);

    muntjac_metadata_table u_table (
        .valid_i (in_range_s),
        .state_i (old_state_s),
        .event_i (stage_event_r),
        .state_o (new_state_s)
    );

    assign resp_valid_o = stage_valid_r;
    assign resp_port_o  = stage_port_r;
    assign resp_old_o   = old_state_s;
    assign resp_new_o   = new_state_s;
    assign resp_err_o   = stage_valid_r & ~in_range_s;
    assign busy_o       = clear_pending_r | (fsm_r == FsmClear);

    // Round-robin arbitration starting at the pointer; ready is held low in reset.
    always_comb begin
        can_accept_s  = (~stage_valid_r | resp_fire_s) & ~clear_pending_r &
                        (fsm_r == FsmIdle) & rst_ni;
        grant_found_s = 1'b0;
        grant_port_s  = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!grant_found_s && req_valid_i[wrap_port(32'(rr_ptr_r) + k)]) begin
                grant_found_s = 1'b1;
                grant_port_s  = wrap_port(32'(rr_ptr_r) + k);
            end
        end
        accept_s    = can_accept_s & grant_found_s;
        rr_next_s   = wrap_port(32'(grant_port_s) + 32'd1);
        sel_idx_s   = req_idx_i[32'(grant_port_s) * IdxW +: IdxW];
        sel_event_s = req_event_i[32'(grant_port_s) * EventWidth +: EventWidth];
        req_ready_o = '0;
        if (accept_s) begin
            req_ready_o[grant_port_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // Clear FSM: a clear waits for the stage to drain before sweeping the table.
    always_comb begin
        fsm_next_s     = fsm_r;
        pending_next_s = clear_pending_r;
        case (fsm_r)
            FsmIdle: begin
                if (clear_pending_r && !stage_valid_r) begin
                    fsm_next_s     = FsmClear;
                    pending_next_s = 1'b0;
                end else if (clear_i) begin
                    pending_next_s = 1'b1;
                end else begin
                    pending_next_s = clear_pending_r;
                end
            end
            FsmClear: begin
                if (clr_cnt_r == IdxW'(NumEntries - 1)) begin
                    fsm_next_s = FsmIdle;
                end else begin
                    fsm_next_s = FsmClear;
                end
            end
            default: begin
                fsm_next_s     = FsmIdle;
                pending_next_s = 1'b0;
            end
        endcase
    end

    // FSM state, pending flag and sweep counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_r           <= FsmIdle;
            clear_pending_r <= 1'b0;
            clr_cnt_r       <= '0;
        end else begin
            fsm_r           <= fsm_next_s;
            clear_pending_r <= pending_next_s;
            if (fsm_r == FsmClear) begin
                clr_cnt_r <= clr_cnt_r + IdxW'(1);
            end
        end
    end

    // Round-robin pointer moves one past each granted port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end

    // Stage register: refilled on accept, emptied when its response fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid_r <= 1'b0;
            stage_port_r  <= '0;
            stage_idx_r   <= '0;
            stage_event_r <= '0;
        end else if (accept_s) begin
            stage_valid_r <= 1'b1;
            stage_port_r  <= grant_port_s;
            stage_idx_r   <= sel_idx_s;
            stage_event_r <= sel_event_s;
        end else if (resp_fire_s) begin
            stage_valid_r <= 1'b0;
        end
    end

    // Entry storage; the stage is always empty while the sweep runs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumEntries; i++) begin
                entry_r[i] <= '0;
            end
        end else if (fsm_r == FsmClear) begin
            entry_r[clr_cnt_r] <= '0;
        end else if (resp_fire_s) begin
            entry_r[stage_idx_r] <= new_state_s;
        end
    end

endmodule

// File: tb/tb_muntjac_metadata_ctrl.sv
// Directed bench for muntjac_metadata_ctrl with an abstract reference model
// checked every cycle plus literal expectations for the key scenarios.
module tb_muntjac_metadata_ctrl;

    localparam int N  = 16;
    localparam int R  = 2;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*IW-1:0] req_idx;
    logic [R*4-1:0]  req_event;
    logic            resp_valid, resp_ready, resp_err, clear, busy;
    logic [0:0]      resp_port;
    logic [7:0]      resp_old, resp_new;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muntjac_metadata_ctrl #(.NumEntries(N), .NumReq(R)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_idx_i    (req_idx),
        .req_event_i  (req_event),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_port_o  (resp_port),
        .resp_old_o   (resp_old),
        .resp_new_o   (resp_new),
        .resp_err_o   (resp_err),
        .clear_i      (clear),
        .busy_o       (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mem [N];
    bit m_valid, m_pending;
    int m_port, m_idx, m_ev, m_rr, m_clear_left;

    function automatic int next_state(int st, int ev);
        if (ev > 3 || st > 3) return st;
        if (ev == 2 && st == 0) return 1;
        if (ev == 3 && st == 1) return 2;
        return st;
    endfunction

    function automatic int exp_grant();
        if (!rst_ni) return -1;
        if (m_valid && !resp_ready) return -1;
        if (m_pending || m_clear_left > 0) return -1;
        for (int k = 0; k < R; k++) begin
            int p = (m_rr + k) % R;
            if (req_valid[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_mem[i] = 0;
        m_valid = 0; m_pending = 0; m_clear_left = 0;
        m_port = 0; m_idx = 0; m_ev = 0; m_rr = 0;
    endtask

    task automatic model_step();
        int  g;
        bit  was_valid;
        g = exp_grant();
        was_valid = m_valid;
        if (m_valid && resp_ready) begin
            m_mem[m_idx] = next_state(m_mem[m_idx], m_ev);
            m_valid = 0;
        end
        if (g >= 0) begin
            m_valid = 1;
            m_port  = g;
            m_idx   = int'(req_idx[g*IW +: IW]);
            m_ev    = int'(req_event[g*4 +: 4]);
            m_rr    = (g + 1) % R;
        end
        if (m_clear_left > 0) begin
            m_mem[N - m_clear_left] = 0;
            m_clear_left--;
        end else if (m_pending && !was_valid) begin
            m_clear_left = N;
            m_pending = 0;
        end else if (clear) begin
            m_pending = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                check("reset_req_ready", int'(req_ready), 0);
                check("reset_resp_valid", int'(resp_valid), 0);
                check("reset_busy", int'(busy), 0);
            end else begin
                int g;
                g = exp_grant();
                check("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
                check("resp_valid", int'(resp_valid), int'(m_valid));
                check("busy", int'(busy), int'(m_pending || m_clear_left > 0));
                if (m_valid) begin
                    check("resp_port", int'(resp_port), m_port);
                    check("resp_old", int'(resp_old), m_mem[m_idx]);
                    check("resp_new", int'(resp_new), next_state(m_mem[m_idx], m_ev));
                    check("resp_err", int'(resp_err), int'(m_ev > 3 || m_mem[m_idx] > 3));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int port, input int idx, input int ev);
        int n;
        req_idx[port*IW +: IW] = IW'(idx);
        req_event[port*4 +: 4] = 4'(ev);
        req_valid[port] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[port] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[port]) check("issue_timeout", int'(req_ready[port]), 1);
        tick();
        req_valid[port] = 1'b0;
    endtask

    task automatic expect_resp(input string name, input int port, input int old_v,
                               input int new_v, input int err);
        @(negedge clk);
        check({name, "_valid"}, int'(resp_valid), 1);
        check({name, "_port"}, int'(resp_port), port);
        check({name, "_old"}, int'(resp_old), old_v);
        check({name, "_new"}, int'(resp_new), new_v);
        check({name, "_err"}, int'(resp_err), err);
        tick();
    endtask

    // Reads an entry through an identity event.
    task automatic check_entry(input string name, input int idx, input int exp);
        issue(0, idx, 0);
        @(negedge clk);
        check(name, int'(resp_old), exp);
        tick();
    endtask

    initial begin
        int n;
        req_valid = '0; req_idx = '0; req_event = '0;
        resp_ready = 1'b1; clear = 1'b0;
        repeat (2) @(negedge clk);
        check("lit_reset_busy", int'(busy), 0);
        check("lit_reset_ready", int'(req_ready), 0);
        tick();
        rst_ni = 1'b1;

        // Two ports contending from pointer 0: grants alternate.
        req_idx = {4'd1, 4'd0};
        req_event = '0;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_grant", int'(req_ready), (i % 2 == 0) ? 1 : 2);
            check("rr_resp_each_cycle", int'(resp_valid), (i > 0) ? 1 : 0);
        end
        tick();
        req_valid = '0;
        tick();

        // Open on entry 5.
        issue(0, 5, 2);
        expect_resp("open5", 0, 0, 1, 0);
        check_entry("entry5_open", 5, 1);

        // Back-to-back open then commit on entry 3.
        req_idx[3:0] = 4'd3; req_event[3:0] = 4'd2; req_valid[0] = 1'b1;
        @(negedge clk);
        check("b2b_ready_first", int'(req_ready[0]), 1);
        tick();
        req_event[3:0] = 4'd3;
        @(negedge clk);
        check("b2b_first_old", int'(resp_old), 0);
        check("b2b_first_new", int'(resp_new), 1);
        check("b2b_ready_second", int'(req_ready[0]), 1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("b2b_second_old", int'(resp_old), 1);
        check("b2b_second_new", int'(resp_new), 2);
        tick();
        check_entry("entry3_commit", 3, 2);

        // Out-of-range event.
        issue(1, 1, 7);
        expect_resp("bad_event", 1, 0, 0, 1);
        check_entry("entry1_unchanged", 1, 0);

        // Backpressure for three cycles, then fire.
        resp_ready = 1'b0;
        issue(0, 5, 3);
        req_idx[7:4] = 4'd9; req_event[7:4] = 4'd0; req_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", int'(resp_valid), 1);
            check("stall_old", int'(resp_old), 1);
            check("stall_new", int'(resp_new), 2);
            check("stall_ready", int'(req_ready), 0);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("fire_accepts_port1", int'(req_ready), 2);
        tick();
        req_valid[1] = 1'b0;
        tick();
        check_entry("entry5_commit", 5, 2);

        // Clear while a response is stalled.
        resp_ready = 1'b0;
        issue(0, 7, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("clear_wait_busy", int'(busy), 1);
            check("clear_wait_resp", int'(resp_valid), 1);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("clear_resp_old", int'(resp_old), 0);
        check("clear_resp_new", int'(resp_new), 1);
        tick();
        // One drained-pending cycle, then one cycle per entry; a second clear mid-sweep is ignored.
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            tick();
            clear = (n == 4);
        end
        clear = 1'b0;
        check("clear_busy_cycles", n, N + 1);
        tick();
        for (int i = 0; i < N; i++) check_entry("entry_cleared", i, 0);

        // Reset during the sweep.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        rst_ni = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("rst_mid_clear_busy", int'(busy), 0);
        check("rst_mid_clear_ready", int'(req_ready), 0);
        tick();
        rst_ni = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("after_rst_busy", int'(busy), 0);
        tick();

        // Reset with a response pending discards it.
        resp_ready = 1'b0;
        issue(0, 2, 2);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("rst_drops_resp", int'(resp_valid), 0);
        tick();
        check_entry("entry2_no_writeback", 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
